fp_recip_multiplier: RTL and testbench

Sequential IEEE-754 single-precision multiplier that consumes the reciprocal word produced by the reciprocal stage and multiplies it by a numerator operand. Together, the two stages implement x / y as x × (1/y) for battery-pack scaling, for example charge × (1/capacity) for state of charge. Operands arrive through a valid/ready handshake. The mantissa product is built by a 24-cycle shift-add engine, then normalized, rounded and held until the consumer accepts it.

---
 rtl/fp_recip_multiplier_if.sv | 23 ++
 rtl/fp_recip_multiplier.sv | 143 ++++++++++++++
 tb/tb_fp_recip_multiplier.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_recip_multiplier_if.sv
// Operand/result handshake bundle for fp_recip_multiplier: valid/ready in, valid/ready out.
interface fp_recip_multiplier_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] numerator;
  logic [31:0] recip;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  modport master (
    output in_valid, numerator, recip, out_ready,
    input  in_ready, out_valid, product, overflow, underflow, invalid
  );

  modport slave (
    input  in_valid, numerator, recip, out_ready,
    output in_ready, out_valid, product, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp_recip_multiplier.sv
// IEEE-754 single x*(1/y) via 24-cycle shift-add; result 26 edges after accept (specials 1), held until out_ready, no overlap.
// FP_MUL_ROUND_NEAREST_EN selects round-to-nearest-even; default build truncates toward zero.
module fp_recip_multiplier #(
  parameter int          MUL_CYCLES = 24,
  parameter logic [31:0] QNAN       = 32'h7FC00000
) (
  input logic                  clk,
  input logic                  rst,
  fp_recip_multiplier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t      state;
  logic        sign;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic [47:0] acc;
  logic [4:0]  cnt;
  logic [31:0] product_r;
  logic        ovf_r, unf_r, inv_r, out_valid_r;

  logic [7:0] xe, ye;
  logic       x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, s_in;

  // Zero exponent covers subnormals, which are flushed to zero on input.
  assign xe     = bus.numerator[30:23];
  assign ye     = bus.recip[30:23];
  assign x_zero = (xe == 8'h00);
  assign y_zero = (ye == 8'h00);
  assign x_inf  = (xe == 8'hFF) && (bus.numerator[22:0] == 23'd0);
  assign y_inf  = (ye == 8'hFF) && (bus.recip[22:0] == 23'd0);
  assign x_nan  = (xe == 8'hFF) && (bus.numerator[22:0] != 23'd0);
  assign y_nan  = (ye == 8'hFF) && (bus.recip[22:0] != 23'd0);
  assign s_in   = bus.numerator[31] ^ bus.recip[31];

  logic signed [9:0] e_base, e_norm, e_fin;
  logic [22:0]       frac_t;
  logic [23:0]       frac_r;
  logic              rnd;

  always_comb begin
    e_base = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (acc[47]) begin
      frac_t = acc[46:24];
      e_norm = e_base + 10'sd1;
    end else begin
      frac_t = acc[45:23];
      e_norm = e_base;
    end
`ifdef FP_MUL_ROUND_NEAREST_EN
    if (acc[47]) rnd = acc[23] && ((|acc[22:0]) || acc[24]);
    else         rnd = acc[22] && ((|acc[21:0]) || acc[23]);
`else
    rnd = 1'b0;
`endif
    // Carry out of the fraction means mantissa 1.0 at the next exponent.
    frac_r = {1'b0, frac_t} + {23'd0, rnd};
    e_fin  = e_norm + $signed({9'd0, frac_r[23]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sign        <= 1'b0;
      ea          <= 8'd0;
      eb          <= 8'd0;
      ma          <= 24'd0;
      mb          <= 24'd0;
      acc         <= 48'd0;
      cnt         <= 5'd0;
      product_r   <= 32'h0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      inv_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign  <= s_in;
            ea    <= xe;
            eb    <= ye;
            ma    <= {1'b1, bus.numerator[22:0]};
            mb    <= {1'b1, bus.recip[22:0]};
            acc   <= 48'd0;
            cnt   <= 5'd0;
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
            inv_r <= 1'b0;
            if (x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf)) begin
              product_r <= QNAN;
              inv_r     <= 1'b1;
              state     <= DONE;
            end else if (x_inf || y_inf) begin
              product_r <= {s_in, 8'hFF, 23'd0};
              state     <= DONE;
            end else if (x_zero || y_zero) begin
              product_r <= {s_in, 31'd0};
              state     <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (mb[0]) acc <= acc + ({24'd0, ma} << cnt);
          mb  <= mb >> 1;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(MUL_CYCLES - 1)) state <= NORM;
        end
        NORM: begin
          if (e_fin >= 10'sd255) begin
            product_r <= {sign, 8'hFF, 23'd0};
            ovf_r     <= 1'b1;
          end else if (e_fin <= 10'sd0) begin
            product_r <= {sign, 31'd0};
            unf_r     <= 1'b1;
          end else begin
            product_r <= {sign, e_fin[7:0], frac_r[22:0]};
          end
          state <= DONE;
        end
        DONE: begin
          // First DONE cycle registers out_valid; result is already stable.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.product   = product_r;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;
  assign bus.invalid   = inv_r;
endmodule

// File: tb/tb_fp_recip_multiplier.sv
// Directed bench for fp_recip_multiplier: arithmetic reference model plus per-cycle output scoreboard.
module tb_fp_recip_multiplier;
  logic clk;
  logic rst;
  fp_recip_multiplier_if bus ();

  fp_recip_multiplier dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FP_MUL_ROUND_NEAREST_EN
  localparam logic [31:0] TIE_EXP = 32'h3FC00002;
`else
  localparam logic [31:0] TIE_EXP = 32'h3FC00001;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [34:0] exp_q[$];   // {invalid, underflow, overflow, product}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: exact integer product, normalize by magnitude, round by remainder vs half.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
    logic s, xz, yz, xi, yi, xn, yn;
    int e, sh;
    logic [47:0] p;
    logic [24:0] m;
`ifdef FP_MUL_ROUND_NEAREST_EN
    logic [47:0] rem, half;
`endif
    s  = x[31] ^ y[31];
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    if (xn || yn || (xi && yz) || (xz && yi)) return {3'b100, 32'h7FC00000};
    if (xi || yi) return {3'b000, s, 8'hFF, 23'd0};
    if (xz || yz) return {3'b000, s, 31'd0};
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p >= 48'h8000_0000_0000) begin sh = 24; e = e + 1; end
    else sh = 23;
    m = 25'(p >> sh);
`ifdef FP_MUL_ROUND_NEAREST_EN
    rem  = p - ((p >> sh) << sh);
    half = 48'd1 << (sh - 1);
    if (rem > half || (rem == half && m[0])) m = m + 25'd1;
`endif
    if (m == 25'h100_0000) begin m = 25'h080_0000; e = e + 1; end
    if (e >= 255) return {3'b001, s, 8'hFF, 23'd0};
    if (e <= 0) return {3'b010, s, 31'd0};
    return {3'b000, s, 8'(e), m[22:0]};
  endfunction

  // Scoreboard: every cycle out_valid is high the held result must match the model.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h, expected no output", bus.product);
      end else begin
        check("product", bus.product, exp_q[0][31:0]);
        check("flags", {29'd0, bus.invalid, bus.underflow, bus.overflow}, {29'd0, exp_q[0][34:32]});
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int exp_lat, input string name);
    int lat;
    bit rdy_low;
    bit seen;
    for (int k = 0; k < 100 && !bus.in_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!bus.in_ready) begin
      check({name, "_accept_timeout"}, 32'd0, 32'd1);
      return;
    end
    exp_q.push_back(model(x, y));
    bus.numerator = x;
    bus.recip     = y;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.numerator = $urandom;
    bus.recip     = $urandom;
    rdy_low = 1'b1;
    seen    = 1'b0;
    lat     = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
      if (bus.in_ready) rdy_low = 1'b0;
    end
    check({name, "_done"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_in_ready_low"}, 32'(rdy_low && !bus.in_ready), 32'd1);
  endtask

  task automatic run_vec(input logic [31:0] x, input logic [31:0] y, input logic [31:0] p,
                         input logic [2:0] f, input int lat, input string name);
    logic [34:0] m;
    m = model(x, y);
    check({name, "_model_product"}, m[31:0], p);
    check({name, "_model_flags"}, {29'd0, m[34:32]}, {29'd0, f});
    do_op(x, y, lat, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.numerator = 32'h0;
    bus.recip     = 32'h0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_product", bus.product, 32'h0);
    check("rst_flags", {29'd0, bus.invalid, bus.underflow, bus.overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    run_vec(32'h40000000, 32'h3F000000, 32'h3F800000, 3'b000, 26, "two_x_half");
    run_vec(32'h3F800001, 32'h3FC00000, TIE_EXP,      3'b000, 26, "tie");
    run_vec(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000, 26, "carry_bit47");
    run_vec(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b001, 26, "overflow");
    run_vec(32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 26, "underflow");
    run_vec(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 1,  "inf_x_zero");
    run_vec(32'hC0000000, 32'h00000000, 32'h80000000, 3'b000, 1,  "neg_x_zero");
    run_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 1,  "nan");
    run_vec(32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000, 1,  "inf_x_neg");
    run_vec(32'h00000001, 32'h40000000, 32'h00000000, 3'b000, 1,  "subnormal");

    // Back-pressure: result held for 10 cycles, then a new op accepted right after release.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    run_vec(32'hC0400000, 32'h40800000, 32'hC1400000, 3'b000, 26, "bp");
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.in_ready || !bus.out_valid) ok = 1'b0;
    end
    check("bp_hold", 32'(ok), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    run_vec(32'h40400000, 32'h3F000000, 32'h3FC00000, 3'b000, 26, "bp_next");

    // Reset during MUL aborts the operation with no output.
    @(posedge clk); #1;
    for (int k = 0; k < 100 && !bus.in_ready; k++) begin
      @(posedge clk); #1;
    end
    bus.numerator = 32'h40000000;
    bus.recip     = 32'h3F000000;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    check("abort_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) ok = 1'b0;
    end
    check("abort_no_output", 32'(ok), 32'd1);
    run_vec(32'h40400000, 32'h3F000000, 32'h3FC00000, 3'b000, 26, "after_abort");

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
